spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 107 ++++++++++
 tb/tb_spi_reg_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank for a 4-channel PWM block.
// Writes land in shadow registers and are copied to the active outputs by a write to UPDATE.
module spi_reg_bank (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_wr,
  input  logic        wr_en,
  output logic [7:0]  data_rd,
  output logic [3:0]  ch_en,
  output logic [7:0]  period,
  output logic [3:0]  prescale,
  output logic [31:0] duty
);

  localparam logic [7:0] ID_VALUE = 8'hA5;

  logic [6:0] addr_dec;
  logic       unused_addr;
  logic       frame_clr_n;
  logic       committed;
  logic       commit;

  logic [3:0] sh_ctrl;
  logic [7:0] sh_period;
  logic [3:0] sh_prescale;
  logic [7:0] sh_duty [4];
  logic [7:0] scratch;
  logic [3:0] wcount;
  logic       upd_done;

  assign addr_dec    = addr[6:0];
  assign unused_addr = addr[7];

  // One commit per frame: the flag is held clear whenever cs is high or reset is asserted.
  assign frame_clr_n = rst_n & ~cs;
  assign commit      = ~cs & wr_en & ~committed;

  always_ff @(posedge sclk or negedge frame_clr_n) begin
    if (!frame_clr_n)
      committed <= 1'b0;
    else if (wr_en)
      committed <= 1'b1;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_ctrl     <= 4'h0;
      sh_period   <= 8'hFF;
      sh_prescale <= 4'h0;
      for (int k = 0; k < 4; k++) sh_duty[k] <= 8'h00;
      ch_en       <= 4'h0;
      period      <= 8'hFF;
      prescale    <= 4'h0;
      duty        <= 32'h0;
      scratch     <= 8'h00;
      wcount      <= 4'h0;
      upd_done    <= 1'b0;
    end else if (commit) begin
      if (addr_dec <= 7'h0A)
        wcount <= wcount + 4'd1;
      case (addr_dec)
        7'h01: sh_ctrl     <= data_wr[3:0];
        7'h02: sh_period   <= data_wr;
        7'h03: sh_prescale <= data_wr[3:0];
        7'h04: sh_duty[0]  <= data_wr;
        7'h05: sh_duty[1]  <= data_wr;
        7'h06: sh_duty[2]  <= data_wr;
        7'h07: sh_duty[3]  <= data_wr;
        7'h08: begin
          if (data_wr[0]) begin
            ch_en    <= sh_ctrl;
            period   <= sh_period;
            prescale <= sh_prescale;
            duty     <= {sh_duty[3], sh_duty[2], sh_duty[1], sh_duty[0]};
            upd_done <= 1'b1;
          end
        end
        7'h09: begin
          if (data_wr[0])
            upd_done <= 1'b0;
        end
        7'h0A: scratch <= data_wr;
        default: ;
      endcase
    end
  end

  always_comb begin
    data_rd = 8'h00;
    case (addr_dec)
      7'h00: data_rd = ID_VALUE;
      7'h01: data_rd = {4'h0, sh_ctrl};
      7'h02: data_rd = sh_period;
      7'h03: data_rd = {4'h0, sh_prescale};
      7'h04: data_rd = sh_duty[0];
      7'h05: data_rd = sh_duty[1];
      7'h06: data_rd = sh_duty[2];
      7'h07: data_rd = sh_duty[3];
      7'h09: data_rd = {wcount, 3'b000, upd_done};
      7'h0A: data_rd = scratch;
      default: data_rd = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed vector table, hand sequences for frame corner cases,
// and random frames checked against a register-map model.
module tb_spi_reg_bank;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [7:0]  addr;
  logic [7:0]  data_wr;
  logic        wr_en;
  logic [7:0]  data_rd;
  logic [3:0]  ch_en;
  logic [7:0]  period;
  logic [3:0]  prescale;
  logic [31:0] duty;

  int n_vec = 0;
  int n_bad = 0;

  spi_reg_bank dut (
    .sclk(sclk), .rst_n(rst_n), .cs(cs), .addr(addr), .data_wr(data_wr),
    .wr_en(wr_en), .data_rd(data_rd), .ch_en(ch_en), .period(period),
    .prescale(prescale), .duty(duty)
  );

  always #5 sclk = ~sclk;

  // Model: register map as plain bytes, indexed by decoded address.
  byte unsigned m_reg [0:10];
  byte unsigned m_act_ctrl, m_act_period, m_act_pre;
  byte unsigned m_act_duty [0:3];
  int           m_wcount;
  bit           m_done;

  function automatic void model_reset();
    for (int i = 0; i <= 10; i++) m_reg[i] = 0;
    m_reg[2] = 8'hFF;
    m_act_ctrl = 0; m_act_period = 8'hFF; m_act_pre = 0;
    for (int i = 0; i < 4; i++) m_act_duty[i] = 0;
    m_wcount = 0;
    m_done = 0;
  endfunction

  function automatic void model_write(input int a, input int d);
    int r;
    r = a % 128;
    if (r > 10) return;
    m_wcount = (m_wcount + 1) % 16;
    case (r)
      1, 3:       m_reg[r] = d % 16;
      2, 4, 5, 6, 7, 10: m_reg[r] = d;
      8: if (d % 2 == 1) begin
           m_act_ctrl = m_reg[1]; m_act_period = m_reg[2]; m_act_pre = m_reg[3];
           for (int i = 0; i < 4; i++) m_act_duty[i] = m_reg[4 + i];
           m_done = 1;
         end
      9: if (d % 2 == 1) m_done = 0;
      default: ;
    endcase
  endfunction

  function automatic int model_read(input int a);
    int r;
    r = a % 128;
    if (r == 0) return 8'hA5;
    if (r == 8 || r > 10) return 0;
    if (r == 9) return m_wcount * 16 + int'(m_done);
    return m_reg[r];
  endfunction

  function automatic int model_duty();
    return m_act_duty[3] * 2**24 + m_act_duty[2] * 2**16 + m_act_duty[1] * 2**8 + m_act_duty[0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(name, {24'h0, data_rd}, {24'h0, exp});
  endtask

  task automatic check_model(input string tag);
    check({tag, " ch_en"},    {28'h0, ch_en},    32'(m_act_ctrl));
    check({tag, " period"},   {24'h0, period},   32'(m_act_period));
    check({tag, " prescale"}, {28'h0, prescale}, 32'(m_act_pre));
    check({tag, " duty"},     duty,              32'(model_duty()));
    for (int a = 0; a <= 11; a++)
      read_chk($sformatf("%s rd%0h", tag, a), 8'(a), 8'(model_read(a)));
    read_chk({tag, " rd_hi"}, 8'h8B + 8'($urandom_range(0, 100)), 8'h00);
  endtask

  // Frame: 16 data clocks with wr_en low, then wr_en high for the 17th edge (+extra),
  // or cs rising before that edge when abort is set.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input int extra, input bit abort);
    @(negedge sclk);
    cs = 1'b0; addr = a; data_wr = d; wr_en = 1'b0;
    repeat (16) @(negedge sclk);
    wr_en = 1'b1;
    if (abort) begin
      #2 cs = 1'b1;
      #1 wr_en = 1'b0;
    end else begin
      repeat (1 + extra) @(negedge sclk);
      cs = 1'b1;
      wr_en = 1'b0;
    end
    @(negedge sclk);
    if (!abort) model_write(a, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  typedef struct {
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp_rd;
    logic [31:0] exp_duty;
    logic [7:0] exp_period;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h05, 8'h40, 8'h05, 8'h40, 32'h0,        8'hFF};
    vecs[1] = '{8'h08, 8'h01, 8'h09, 8'h21, 32'h00004000, 8'hFF};
    vecs[2] = '{8'h20, 8'hFF, 8'h09, 8'h21, 32'h00004000, 8'hFF};
    vecs[3] = '{8'h08, 8'h00, 8'h09, 8'h31, 32'h00004000, 8'hFF};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'hA5, 32'h00004000, 8'hFF};
    vecs[5] = '{8'h02, 8'h80, 8'h02, 8'h80, 32'h00004000, 8'hFF};
    vecs[6] = '{8'h09, 8'hFE, 8'h09, 8'h61, 32'h00004000, 8'hFF};
    vecs[7] = '{8'h09, 8'h01, 8'h09, 8'h70, 32'h00004000, 8'hFF};
    vecs[8] = '{8'h8A, 8'h3C, 8'h0A, 8'h3C, 32'h00004000, 8'hFF};

    cs = 1'b1; addr = 8'h00; data_wr = 8'h00; wr_en = 1'b0; rst_n = 1'b1;
    #2;
    do_reset();

    check("rst ch_en", {28'h0, ch_en}, 32'h0);
    check("rst period", {24'h0, period}, 32'hFF);
    check("rst prescale", {28'h0, prescale}, 32'h0);
    check("rst duty", duty, 32'h0);
    read_chk("rst id", 8'h00, 8'hA5);
    read_chk("rst status", 8'h09, 8'h00);
    read_chk("rst period_rd", 8'h02, 8'hFF);

    for (int i = 0; i < 9; i++) begin
      do_frame(vecs[i].waddr, vecs[i].wdata, 0, 1'b0);
      read_chk($sformatf("vec%0d rd", i), vecs[i].raddr, vecs[i].exp_rd);
      check($sformatf("vec%0d duty", i), duty, vecs[i].exp_duty);
      check($sformatf("vec%0d period", i), {24'h0, period}, {24'h0, vecs[i].exp_period});
      check_model($sformatf("vec%0d", i));
    end

    // Extra sclk edges with wr_en held must not produce a second commit.
    do_frame(8'h0A, 8'h5A, 5, 1'b0);
    read_chk("hold scratch", 8'h0A, 8'h5A);
    read_chk("hold status", 8'h09, 8'h90);

    do_reset();
    for (int i = 0; i < 16; i++) do_frame(8'h0A, 8'(i), 0, 1'b0);
    read_chk("wrap status", 8'h09, 8'h00);
    do_frame(8'h08, 8'h01, 0, 1'b0);
    do_frame(8'h09, 8'h01, 0, 1'b0);
    read_chk("w1c status", 8'h09, 8'h20);

    do_frame(8'h02, 8'h33, 0, 1'b1);
    read_chk("abort period", 8'h02, 8'hFF);
    read_chk("abort status", 8'h09, 8'h20);

    // Reset during a frame, then release while cs stays low with wr_en low.
    do_frame(8'h04, 8'h77, 0, 1'b0);
    do_frame(8'h08, 8'h01, 0, 1'b0);
    @(negedge sclk);
    cs = 1'b0; addr = 8'h0A; data_wr = 8'hEE; wr_en = 1'b0;
    repeat (8) @(negedge sclk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("midrst duty", duty, 32'h0);
    check("midrst period", {24'h0, period}, 32'hFF);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    cs = 1'b1;
    @(negedge sclk);
    check_model("midrst");
    read_chk("midrst scratch", 8'h0A, 8'h00);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      int sel;
      sel = int'($urandom_range(0, 19));
      a = (sel < 17) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(12, 127));
      if ($urandom_range(0, 3) == 0) a[7] = 1'b1;
      d = 8'($urandom);
      do_frame(a, d, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      if (i % 5 == 4) check_model($sformatf("rnd%0d", i));
      else read_chk($sformatf("rnd%0d st", i), 8'h09, 8'(model_read(9)));
    end
    check_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
